// File: rtl/bp_fe_dual_fetch_queue.sv
// Fetch queue between the dual-issue PC generator and the backend: splits 2-wide fetch
// packets into per-instruction entries and presents up to two in-order entries per cycle.
// Optional same-cycle bypass on an empty queue when BP_FE_FQ_BYPASS_EN is defined.
module bp_fe_dual_fetch_queue #(
    parameter int vaddr_width_p               = 39,
    parameter int instr_width_gp              = 32,
    parameter int branch_metadata_fwd_width_p = 35,
    parameter int els_p                       = 8
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   flush_i,

    input  logic                                   enq_v_i,
    output logic                                   enq_ready_o,
    input  logic [vaddr_width_p-1:0]               enq_pc_i,
    input  logic [instr_width_gp-1:0]              enq_instr1_i,
    input  logic [instr_width_gp-1:0]              enq_instr2_i,
    input  logic                                   enq_instr_v1_i,
    input  logic                                   enq_instr_v2_i,
    input  logic                                   enq_exc_v1_i,
    input  logic                                   enq_exc_v2_i,
    input  logic [branch_metadata_fwd_width_p-1:0] enq_br_metadata_fwd_i,

    output logic [1:0]                             deq_v_o,
    output logic [vaddr_width_p-1:0]               deq_pc1_o,
    output logic [vaddr_width_p-1:0]               deq_pc2_o,
    output logic [instr_width_gp-1:0]              deq_instr1_o,
    output logic [instr_width_gp-1:0]              deq_instr2_o,
    output logic                                   deq_exc1_o,
    output logic                                   deq_exc2_o,
    output logic [branch_metadata_fwd_width_p-1:0] deq_br_metadata_fwd1_o,
    output logic [branch_metadata_fwd_width_p-1:0] deq_br_metadata_fwd2_o,
    input  logic [1:0]                             deq_yumi_i
);

    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p + 1);

    typedef struct packed {
        logic [vaddr_width_p-1:0]               pc;
        logic [instr_width_gp-1:0]              instr;
        logic                                   exc;
        logic [branch_metadata_fwd_width_p-1:0] md;
    } entry_t;

    entry_t           mem_q [els_p];
    entry_t           mem_d [els_p];
    logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0] rd_ptr_p1, wr_ptr_p1;
    logic [cnt_w-1:0] count_q, count_d, free_cnt;

    logic   enq_fire, wr1, wr2;
    logic [1:0] n_wr, n_deq;
    entry_t ent1, ent2, first_ent, head0, head1;

    assign free_cnt    = cnt_w'(els_p) - count_q;
    assign enq_ready_o = ~reset_i & (free_cnt >= cnt_w'(2));
    assign enq_fire    = enq_v_i & enq_ready_o & ~flush_i;

    // A slot-1 exception ends the packet: slot 2 is never written behind it.
    assign wr1 = enq_fire & (enq_instr_v1_i | enq_exc_v1_i);
    assign wr2 = enq_fire & (enq_instr_v2_i | enq_exc_v2_i) & ~(wr1 & enq_exc_v1_i);

    assign n_wr  = {1'b0, wr1} + {1'b0, wr2};
    assign n_deq = {1'b0, deq_yumi_i[0]} + {1'b0, deq_yumi_i[1]};

    assign ent1 = '{pc: enq_pc_i, instr: enq_instr1_i, exc: enq_exc_v1_i,
                    md: enq_br_metadata_fwd_i};
    assign ent2 = '{pc: enq_pc_i + vaddr_width_p'(4), instr: enq_instr2_i,
                    exc: enq_exc_v2_i, md: enq_br_metadata_fwd_i};
    assign first_ent = wr1 ? ent1 : ent2;

    assign rd_ptr_p1 = rd_ptr_q + ptr_w'(1);
    assign wr_ptr_p1 = wr_ptr_q + ptr_w'(1);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (n_wr != 2'd0) mem_d[wr_ptr_q]  = first_ent;
        if (n_wr == 2'd2) mem_d[wr_ptr_p1] = ent2;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + ptr_w'(n_deq);
            wr_ptr_d = wr_ptr_q + ptr_w'(n_wr);
            count_d  = count_q + cnt_w'(n_wr) - cnt_w'(n_deq);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left uninitialised on reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_comb begin
`ifdef BP_FE_FQ_BYPASS_EN
        // On an empty queue the incoming entries are shown directly; consumed ones are
        // still written but the read pointer skips past them in the same update.
        if (count_q == '0 && n_wr != 2'd0) begin
            head0   = first_ent;
            head1   = ent2;
            deq_v_o = {n_wr == 2'd2, 1'b1};
        end else begin
            head0   = mem_q[rd_ptr_q];
            head1   = mem_q[rd_ptr_p1];
            deq_v_o = {count_q >= cnt_w'(2), count_q != '0};
        end
`else
        head0   = mem_q[rd_ptr_q];
        head1   = mem_q[rd_ptr_p1];
        deq_v_o = {count_q >= cnt_w'(2), count_q != '0};
`endif
    end

    assign deq_pc1_o              = head0.pc;
    assign deq_pc2_o              = head1.pc;
    assign deq_instr1_o           = head0.instr;
    assign deq_instr2_o           = head1.instr;
    assign deq_exc1_o             = head0.exc;
    assign deq_exc2_o             = head1.exc;
    assign deq_br_metadata_fwd1_o = head0.md;
    assign deq_br_metadata_fwd2_o = head1.md;

    always_ff @(posedge clk_i) begin
        if (!reset_i && !flush_i) begin
            assert (!(deq_yumi_i[1] && !deq_yumi_i[0])
                    && (!deq_yumi_i[0] || deq_v_o[0])
                    && (!deq_yumi_i[1] || deq_v_o[1]));
        end
    end

endmodule

// File: tb/tb_bp_fe_dual_fetch_queue.sv
// Randomised bench for bp_fe_dual_fetch_queue against a queue-based reference model,
// with directed sequences for enqueue, exceptions, fill/wrap, flush and bypass.
module tb_bp_fe_dual_fetch_queue;

    localparam int VA  = 39;
    localparam int IW  = 32;
    localparam int MW  = 35;
    localparam int ELS = 8;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          flush_i = 1'b0;
    logic          enq_v_i = 1'b0;
    logic          enq_ready_o;
    logic [VA-1:0] enq_pc_i = '0;
    logic [IW-1:0] enq_instr1_i = '0, enq_instr2_i = '0;
    logic          enq_instr_v1_i = 1'b0, enq_instr_v2_i = 1'b0;
    logic          enq_exc_v1_i = 1'b0, enq_exc_v2_i = 1'b0;
    logic [MW-1:0] enq_md_i = '0;
    logic [1:0]    deq_v_o;
    logic [VA-1:0] deq_pc1_o, deq_pc2_o;
    logic [IW-1:0] deq_instr1_o, deq_instr2_o;
    logic          deq_exc1_o, deq_exc2_o;
    logic [MW-1:0] deq_md1_o, deq_md2_o;
    logic [1:0]    deq_yumi_i = 2'b00;

    always #5 clk = ~clk;

    bp_fe_dual_fetch_queue #(
        .vaddr_width_p(VA), .instr_width_gp(IW),
        .branch_metadata_fwd_width_p(MW), .els_p(ELS)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
        .enq_v_i(enq_v_i), .enq_ready_o(enq_ready_o), .enq_pc_i(enq_pc_i),
        .enq_instr1_i(enq_instr1_i), .enq_instr2_i(enq_instr2_i),
        .enq_instr_v1_i(enq_instr_v1_i), .enq_instr_v2_i(enq_instr_v2_i),
        .enq_exc_v1_i(enq_exc_v1_i), .enq_exc_v2_i(enq_exc_v2_i),
        .enq_br_metadata_fwd_i(enq_md_i),
        .deq_v_o(deq_v_o), .deq_pc1_o(deq_pc1_o), .deq_pc2_o(deq_pc2_o),
        .deq_instr1_o(deq_instr1_o), .deq_instr2_o(deq_instr2_o),
        .deq_exc1_o(deq_exc1_o), .deq_exc2_o(deq_exc2_o),
        .deq_br_metadata_fwd1_o(deq_md1_o), .deq_br_metadata_fwd2_o(deq_md2_o),
        .deq_yumi_i(deq_yumi_i)
    );

    typedef struct {
        logic [VA-1:0] pc;
        logic [IW-1:0] instr;
        logic          exc;
        logic [MW-1:0] md;
    } ent_t;

    ent_t          model_q[$];
    int            n_cmp = 0;
    int            n_mis = 0;
    logic [MW-1:0] last_md;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then update the model.
    task automatic step(input logic rst, input logic fl, input logic ev, input logic [VA-1:0] pc,
                        input logic v1, input logic v2, input logic x1, input logic x2,
                        input int yreq);
        ent_t       e1, e2;
        ent_t       wr[$];
        ent_t       view[$];
        logic       exp_ready, fire;
        logic [1:0] yumi;
        int         nview, ndeq;
        logic [MW-1:0] md;

        md = MW'({$urandom(), $urandom()});
        last_md = md;
        e1 = '{pc: pc, instr: $urandom(), exc: x1, md: md};
        e2 = '{pc: pc + VA'(4), instr: $urandom(), exc: x2, md: md};

        @(negedge clk);
        exp_ready = !rst && ((ELS - model_q.size()) >= 2);
        fire = ev && exp_ready && !fl;
        if (fire) begin
            if (v1 || x1) wr.push_back(e1);
            if ((v2 || x2) && !((v1 || x1) && x1)) wr.push_back(e2);
        end
        view = model_q;
`ifdef BP_FE_FQ_BYPASS_EN
        if (model_q.size() == 0 && fire) view = wr;
`endif
        nview = view.size();
        if (yreq >= 2 && nview >= 2) yumi = 2'b11;
        else if (yreq >= 1 && nview >= 1) yumi = 2'b01;
        else yumi = 2'b00;
        ndeq = (yumi == 2'b11) ? 2 : (yumi == 2'b01) ? 1 : 0;

        reset_i = rst; flush_i = fl; enq_v_i = ev; enq_pc_i = pc;
        enq_instr1_i = e1.instr; enq_instr2_i = e2.instr;
        enq_instr_v1_i = v1; enq_instr_v2_i = v2;
        enq_exc_v1_i = x1; enq_exc_v2_i = x2;
        enq_md_i = md; deq_yumi_i = yumi;

        #1;
        chk_val("enq_ready", 64'(enq_ready_o), 64'(exp_ready));
        chk_val("deq_v", 64'(deq_v_o), 64'({nview >= 2, nview >= 1}));
        if (nview >= 1) begin
            chk_val("pc1", 64'(deq_pc1_o), 64'(view[0].pc));
            chk_val("instr1", 64'(deq_instr1_o), 64'(view[0].instr));
            chk_val("exc1", 64'(deq_exc1_o), 64'(view[0].exc));
            chk_val("md1", 64'(deq_md1_o), 64'(view[0].md));
        end
        if (nview >= 2) begin
            chk_val("pc2", 64'(deq_pc2_o), 64'(view[1].pc));
            chk_val("instr2", 64'(deq_instr2_o), 64'(view[1].instr));
            chk_val("exc2", 64'(deq_exc2_o), 64'(view[1].exc));
            chk_val("md2", 64'(deq_md2_o), 64'(view[1].md));
        end

        @(posedge clk);
        if (rst || fl) begin
            model_q.delete();
        end else begin
            foreach (wr[i]) model_q.push_back(wr[i]);
            repeat (ndeq) void'(model_q.pop_front());
        end
        #1;
        reset_i = 1'b0; flush_i = 1'b0; enq_v_i = 1'b0; deq_yumi_i = 2'b00;
        enq_instr_v1_i = 1'b0; enq_instr_v2_i = 1'b0;
        enq_exc_v1_i = 1'b0; enq_exc_v2_i = 1'b0;
    endtask

    task automatic enq2(input logic [VA-1:0] pc, input int yreq);
        step(1'b0, 1'b0, 1'b1, pc, 1'b1, 1'b1, 1'b0, 1'b0, yreq);
    endtask

    task automatic idle(input int yreq);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, yreq);
    endtask

    task automatic do_flush();
        step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        logic [VA-1:0] rpc;
        repeat (2) @(posedge clk);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // basic enqueue
        enq2(VA'(32'h1000), 0);
        #1;
        chk_val("basic_v", 64'(deq_v_o), 64'(2'b11));
        chk_val("basic_pc1", 64'(deq_pc1_o), 64'h1000);
        chk_val("basic_pc2", 64'(deq_pc2_o), 64'h1004);
        chk_val("basic_md1", 64'(deq_md1_o), 64'(last_md));
        chk_val("basic_md2", 64'(deq_md2_o), 64'(last_md));
        idle(2);

        // slot-1 exception drops slot 2
        step(1'b0, 1'b0, 1'b1, VA'(32'h2000), 1'b1, 1'b1, 1'b1, 1'b0, 0);
        #1;
        chk_val("exc_v", 64'(deq_v_o), 64'(2'b01));
        chk_val("exc_flag", 64'(deq_exc1_o), 64'h1);
        chk_val("exc_pc", 64'(deq_pc1_o), 64'h2000);
        idle(1);

        // fill, drain, wrap
        for (int i = 0; i < 4; i++) enq2(VA'(32'h5000 + 8 * i), 0);
        #1;
        chk_val("full_ready", 64'(enq_ready_o), 64'h0);
        chk_val("full_v", 64'(deq_v_o), 64'(2'b11));
        idle(2);
        #1;
        chk_val("after_deq_ready", 64'(enq_ready_o), 64'h1);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) enq2(VA'(32'h7000 + 8 * i), 0);
            else idle(2);
        end
        repeat (6) idle(2);

        // simultaneous enqueue and dequeue from count 3
        do_flush();
        enq2(VA'(32'h8000), 0);
        step(1'b0, 1'b0, 1'b1, VA'(32'h8008), 1'b1, 1'b0, 1'b0, 1'b0, 0);
        enq2(VA'(32'h8010), 1);
        #1;
        chk_val("simul_pc1", 64'(deq_pc1_o), 64'h8004);
        chk_val("simul_ready", 64'(enq_ready_o), 64'h1);
        repeat (3) idle(1);

        // flush with same-cycle enqueue
        do_flush();
        enq2(VA'(32'h9000), 0);
        enq2(VA'(32'h9008), 0);
        step(1'b0, 1'b0, 1'b1, VA'(32'h9010), 1'b1, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b1, VA'(32'h6000), 1'b1, 1'b1, 1'b0, 1'b0, 0);
        #1;
        chk_val("flush_v", 64'(deq_v_o), 64'(2'b00));
        enq2(VA'(32'h3000), 0);
        #1;
        chk_val("flush_head_pc", 64'(deq_pc1_o), 64'h3000);
        do_flush();

`ifdef BP_FE_FQ_BYPASS_EN
        enq2(VA'(32'h4000), 1);
        #1;
        chk_val("byp_v", 64'(deq_v_o), 64'(2'b01));
        chk_val("byp_pc", 64'(deq_pc1_o), 64'h4004);
        do_flush();
`endif

        // mid-operation reset
        enq2(VA'(32'hA000), 0);
        step(1'b1, 1'b0, 1'b1, VA'(32'hB000), 1'b1, 1'b1, 1'b0, 1'b0, 1);
        #1;
        chk_val("rst_v", 64'(deq_v_o), 64'(2'b00));
        chk_val("rst_ready", 64'(enq_ready_o), 64'h1);

        for (int i = 0; i < 800; i++) begin
            rpc = VA'({$urandom(), $urandom()});
            rpc[1:0] = 2'b00;
            step($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 9) < 7, rpc,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
